vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates the 640x480@60 Hz VGA raster timing that drives the display path. It divides the system clock down to a pixel-rate enable and runs horizontal and vertical counters, producing `hsync`, `vsync`, `video_on`, `pixel_x` and `pixel_y`. The pixel coordinates and `video_on` feed the balance/status renderer, and the sync outputs go to the VGA connector. It is the source end of the `pixel_x`/`pixel_y`/`video_on` interface that the renderers consume.

## Interface
- `CLK_DIV`, default 4: system clocks per pixel (100 MHz to 25 MHz). Must be at least 1.
- `H_ACTIVE`, `H_FP`, `H_SYNC`, `H_BP`, defaults 640, 16, 96, 48: horizontal segment lengths in pixels.
- `V_ACTIVE`, `V_FP`, `V_SYNC`, `V_BP`, defaults 480, 10, 2, 33: vertical segment lengths in lines.
- `SYNC_ACTIVE`, default 0: level of `hsync`/`vsync` during the sync pulse (0 means negative polarity).
- `clk` input 1: system clock. This is the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: run enable. While low, all state holds.
- `pixel_tick` output 1: one-`clk` pulse marking each pixel period.
- `hsync` output 1: horizontal sync.
- `vsync` output 1: vertical sync.
- `video_on` output 1: high while the current counter position is in the active region.
- `pixel_x` output 10: raw horizontal count, 0 to H_TOTAL-1.
- `pixel_y` output 10: raw vertical count, 0 to V_TOTAL-1.
- `line_start` output 1: one-`clk` pulse when the horizontal count wraps to 0.
- `frame_start` output 1: one-`clk` pulse when the counters wrap to (0,0).

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 800.
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP = 525.
  - Both totals must fit in 10 bits. This is checked at elaboration.
- Divider:
  - `div_cnt` counts 0 to CLK_DIV-1 while `en` is high, then wraps.
  - `pixel_tick` = `en` && (`div_cnt` == CLK_DIV-1).
  - With CLK_DIV = 1, `pixel_tick` equals `en`.
- Counters:
  - On each `pixel_tick`, `h_cnt` increments. At H_TOTAL-1 it wraps to 0.
  - On each horizontal wrap, `v_cnt` increments. At V_TOTAL-1 it wraps to 0.
- Decodes (a function of the counter values):
  - `video_on` = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
  - `hsync` = SYNC_ACTIVE when `h_cnt` is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751]. Otherwise it is the inverse.
  - `vsync` = SYNC_ACTIVE when `v_cnt` is in [490, 491]. Otherwise it is the inverse.
- Outputs:
  - `pixel_x` = `h_cnt` and `pixel_y` = `v_cnt` unconditionally. Consumers gate with `video_on`.
  - All decoded outputs are registered, computed from next-state counter values, so they change on the same edge as the counters. There is no skew between coordinates and syncs.
- Pulses:
  - `line_start` is high for the single `clk` cycle after the edge where `h_cnt` becomes 0 by wrapping.
  - `frame_start` is high for the single `clk` cycle after the edge where both counters become 0 by wrapping.
  - Reset alone does not generate either pulse.
- Enable:
  - `en` low freezes `div_cnt`, the counters and every registered output.
  - `pixel_tick`, `line_start` and `frame_start` are 0 while `en` is low.
  - Resuming `en` continues from the frozen position, with no skip or repeat.

## Timing
- Reset values:
  - `div_cnt`, `h_cnt`, `v_cnt` = 0.
  - `pixel_x` = 0, `pixel_y` = 0.
  - `video_on` = 0. It goes high on the first clock edge after reset is released.
  - `hsync` = `vsync` = !SYNC_ACTIVE.
  - `pixel_tick`, `line_start`, `frame_start` = 0.
- Reset applies asynchronously mid-frame. The counters restart at (0,0) with no partial-line output.
- First `pixel_tick` after reset: with `en` high, it is asserted in clk cycle CLK_DIV-1 after release (cycle index 3 at default).
- Latency: an output update lands on the same clk edge that consumes the `pixel_tick`.
- Periods:
  - Line: H_TOTAL × CLK_DIV = 3200 clk.
  - Frame: 525 × 3200 = 1,680,000 clk.
  - `hsync` pulse: 96 pixels. `vsync` pulse: 2 lines, i.e. 1600 pixels.
- Simultaneous horizontal and vertical wrap: `line_start` and `frame_start` both pulse in the same cycle.

## Structure
- Shared package `vga_pkg` holds:
  - the 640x480 timing constants;
  - H_TOTAL and V_TOTAL;
  - sync start/end positions;
  - coordinate width (10).
- Renderers import the same package.
- One sub-module, `vga_pixel_tick`: the CLK_DIV divider with `en` and async reset, producing `pixel_tick`.
- Counters, decode and pulse registers live in the top level.

## Test plan
- Reset, then hold `rst_n` low: all outputs at their reset values, `hsync` = `vsync` = 1. After release with `en` = 1, the first `pixel_tick` comes at cycle 3 and repeats every 4 clk.
- Run one line: `video_on` high for `pixel_x` 0 to 639. `hsync` low for exactly `pixel_x` 656 to 751. `line_start` pulses once per 3200 clk.
- Run a full frame: `vsync` low for `pixel_y` 490 to 491. `frame_start` pulses once, 1,680,000 clk after the first wrap reference. `pixel_y` never exceeds 524 and `pixel_x` never exceeds 799.
- Drop `en` at `pixel_x` = 700 for 50 clk: all outputs hold. On resume, the next pixel is 701 with no tick lost.
- Assert `rst_n` low asynchronously (between edges) at `pixel_y` = 300: outputs reset immediately. After release, counting restarts from (0,0) and no `frame_start` is generated by the reset.
- Elaborate with CLK_DIV = 1: `pixel_tick` equals `en`, and the line period is 800 clk.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and helpers for the VGA display path
package vga_pkg;
   localparam int COORD_W      = 10;
   localparam int VGA_CLK_DIV  = 4;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
   localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC - 1;
   localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
   localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC - 1;

   function automatic logic sync_level(input logic in_pulse, input logic active);
      return in_pulse ? active : !active;
   endfunction
endpackage

// File: rtl/vga_pixel_tick.sv
// vga_pixel_tick: divides clk by CLK_DIV into a one-cycle pixel enable
module vga_pixel_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic pixel_tick
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;

   if (CLK_DIV < 1) begin : g_div_chk
      $error("vga_pixel_tick: CLK_DIV must be at least 1");
   end

   always_comb begin
      pixel_tick = en && (div_q == DIV_LAST);
      div_d      = !en ? div_q : (pixel_tick ? '0 : div_q + 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div_q <= '0;
      else        div_q <= div_d;
   end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync/blank decodes and line/frame pulses
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int   CLK_DIV     = VGA_CLK_DIV,
   parameter int   H_ACTIVE    = VGA_H_ACTIVE,
   parameter int   H_FP        = VGA_H_FP,
   parameter int   H_SYNC      = VGA_H_SYNC,
   parameter int   H_BP        = VGA_H_BP,
   parameter int   V_ACTIVE    = VGA_V_ACTIVE,
   parameter int   V_FP        = VGA_V_FP,
   parameter int   V_SYNC      = VGA_V_SYNC,
   parameter int   V_BP        = VGA_V_BP,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   output logic               pixel_tick,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               line_start,
   output logic               frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
   logic               h_wrap, v_wrap;
   logic               video_on_q, hsync_q, vsync_q, line_q, frame_q;

   if (H_TOTAL > 2**COORD_W || V_TOTAL > 2**COORD_W) begin : g_size_chk
      $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit the coordinate width");
   end

   vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_pixel_tick (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .pixel_tick (pixel_tick)
   );

   always_comb begin
      h_wrap = pixel_tick && (h_q == H_LAST);
      v_wrap = h_wrap && (v_q == V_LAST);
      h_d    = !pixel_tick ? h_q : (h_wrap ? '0 : h_q + 1'b1);
      v_d    = !h_wrap ? v_q : (v_wrap ? '0 : v_q + 1'b1);
   end

   // decodes use next-state counts so they land on the same edge as the coordinates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q        <= '0;
         v_q        <= '0;
         video_on_q <= 1'b0;
         hsync_q    <= !SYNC_ACTIVE;
         vsync_q    <= !SYNC_ACTIVE;
         line_q     <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         line_q  <= h_wrap;
         frame_q <= v_wrap;
         if (en) begin
            h_q        <= h_d;
            v_q        <= v_d;
            video_on_q <= (h_d < H_ACT) && (v_d < V_ACT);
            hsync_q    <= sync_level((h_d >= HS_START) && (h_d <= HS_END), SYNC_ACTIVE);
            vsync_q    <= sync_level((v_d >= VS_START) && (v_d <= VS_END), SYNC_ACTIVE);
         end
      end
   end

   assign pixel_x     = h_q;
   assign pixel_y     = v_q;
   assign video_on    = video_on_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = line_q;
   assign frame_start = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three geometries checked against an arithmetic raster model
module tb_vga_timing_gen;
   typedef struct packed {
      logic       tick;
      logic       hs;
      logic       vs;
      logic       vid;
      logic [9:0] x;
      logic [9:0] y;
      logic       ls;
      logic       fs;
   } out_t;

   // dut0 default 640x480, dut1 tiny raster with positive sync, dut2 default with CLK_DIV=1
   int CD  [3] = '{4, 2, 1};
   int HA  [3] = '{640, 16, 640};
   int HFP [3] = '{16, 2, 16};
   int HSY [3] = '{96, 3, 96};
   int HBP [3] = '{48, 4, 48};
   int VA  [3] = '{480, 10, 480};
   int VFP [3] = '{10, 2, 10};
   int VSY [3] = '{2, 2, 2};
   int VBP [3] = '{33, 3, 33};
   bit SA  [3] = '{1'b0, 1'b1, 1'b0};

   logic       clk = 1'b0;
   logic [2:0] rst_n = '0, en = '0;
   logic [2:0] tick, hs, vs, vid, ls, fs;
   logic [9:0] px [3];
   logic [9:0] py [3];
   longint     ec [3];
   bit         lt [3];
   int         n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(.CLK_DIV(4)) d0 (
      .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .pixel_tick(tick[0]), .hsync(hs[0]), .vsync(vs[0]),
      .video_on(vid[0]), .pixel_x(px[0]), .pixel_y(py[0]), .line_start(ls[0]), .frame_start(fs[0]));

   vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
                    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACTIVE(1'b1)) d1 (
      .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .pixel_tick(tick[1]), .hsync(hs[1]), .vsync(vs[1]),
      .video_on(vid[1]), .pixel_x(px[1]), .pixel_y(py[1]), .line_start(ls[1]), .frame_start(fs[1]));

   vga_timing_gen #(.CLK_DIV(1)) d2 (
      .clk(clk), .rst_n(rst_n[2]), .en(en[2]), .pixel_tick(tick[2]), .hsync(hs[2]), .vsync(vs[2]),
      .video_on(vid[2]), .pixel_x(px[2]), .pixel_y(py[2]), .line_start(ls[2]), .frame_start(fs[2]));

   // model state: enabled clk edges since reset, and whether the last edge consumed a tick
   always @(posedge clk)
      for (int i = 0; i < 3; i++) begin
         if (!rst_n[i]) begin
            ec[i] <= 0;
            lt[i] <= 1'b0;
         end else begin
            ec[i] <= ec[i] + (en[i] ? 1 : 0);
            lt[i] <= en[i] && (ec[i] % CD[i] == CD[i] - 1);
         end
      end

   function automatic out_t exp_out(int i);
      out_t   e;
      longint t;
      int     ht, vt, x, y;
      ht = HA[i] + HFP[i] + HSY[i] + HBP[i];
      vt = VA[i] + VFP[i] + VSY[i] + VBP[i];
      t  = ec[i] / CD[i];
      x  = int'(t % ht);
      y  = int'((t / ht) % vt);
      e.tick = en[i] && (ec[i] % CD[i] == CD[i] - 1);
      e.hs   = (x >= HA[i] + HFP[i] && x < HA[i] + HFP[i] + HSY[i]) ? SA[i] : !SA[i];
      e.vs   = (y >= VA[i] + VFP[i] && y < VA[i] + VFP[i] + VSY[i]) ? SA[i] : !SA[i];
      e.vid  = (ec[i] > 0) && (x < HA[i]) && (y < VA[i]);
      e.x    = 10'(x);
      e.y    = 10'(y);
      e.ls   = lt[i] && (x == 0);
      e.fs   = lt[i] && (x == 0) && (y == 0);
      return e;
   endfunction

   function automatic out_t obs(int i);
      out_t o;
      o.tick = tick[i]; o.hs = hs[i]; o.vs = vs[i]; o.vid = vid[i];
      o.x = px[i]; o.y = py[i]; o.ls = ls[i]; o.fs = fs[i];
      return o;
   endfunction

   function automatic out_t reset_val(int i);
      return out_t'{1'b0, !SA[i], !SA[i], 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
   endfunction

   task automatic test_reset();
      int first [3] = '{-1, -1, -1};
      int cnt0 = 0, last0 = -1, bad = 0;
      logic v0, v1;
      string msg;
      rst_n = '0;
      en    = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (obs(i) !== reset_val(i)) $display("FAIL reset_dut%0d: got %p expected %p", i, obs(i), reset_val(i));
         else n_pass++;
      end
      rst_n = '1;
      en    = '1;
      for (int k = 0; k < 13; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (tick[i] === 1'b1 && first[i] < 0) first[i] = k;
            if (obs(i) !== exp_out(i)) begin
               if (bad == 0) msg = $sformatf("dut%0d got %p expected %p", i, obs(i), exp_out(i));
               bad++;
            end
         end
         if (tick[0] === 1'b1) begin cnt0++; last0 = k; end
         if (k == 0) v0 = vid[0];
         if (k == 1) v1 = vid[0];
      end
      n_chk++; if (first[0] !== 3) $display("FAIL first_tick_div4: got %0d expected 3", first[0]); else n_pass++;
      n_chk++; if (first[1] !== 1) $display("FAIL first_tick_div2: got %0d expected 1", first[1]); else n_pass++;
      n_chk++; if (first[2] !== 0) $display("FAIL first_tick_div1: got %0d expected 0", first[2]); else n_pass++;
      n_chk++;
      if (cnt0 !== 3 || last0 !== 11) $display("FAIL tick_period: got %0d ticks last %0d expected 3 last 11", cnt0, last0);
      else n_pass++;
      n_chk++; if (v0 !== 1'b0) $display("FAIL video_on_at_release: got %b expected 0", v0); else n_pass++;
      n_chk++; if (v1 !== 1'b1) $display("FAIL video_on_first_edge: got %b expected 1", v1); else n_pass++;
      n_chk++; if (bad !== 0) $display("FAIL release_model: %0d bad, first %s", bad, msg); else n_pass++;
   endtask

   task automatic test_line();
      longint lse[$];
      int bad = 0, hbad = 0, vbad = 0, hlo = 0;
      string msg;
      for (int k = 0; k < 6600; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            if (obs(i) !== exp_out(i)) begin
               if (bad == 0) msg = $sformatf("dut%0d got %p expected %p", i, obs(i), exp_out(i));
               bad++;
            end
         if (ls[0] === 1'b1) lse.push_back(ec[0]);
         if (tick[0] === 1'b1) begin
            if (vid[0] !== (px[0] < 10'd640)) vbad++;
            if ((hs[0] === 1'b0) !== (px[0] >= 10'd656 && px[0] <= 10'd751)) hbad++;
            if (hs[0] === 1'b0) hlo++;
         end
      end
      n_chk++;
      if (lse.size() != 2 || lse[0] != 3200 || lse[1] != 6400)
         $display("FAIL line_start_period: got %0d pulses %p expected at 3200 and 6400", lse.size(), lse);
      else n_pass++;
      n_chk++; if (hlo !== 192) $display("FAIL hsync_width: got %0d pixels expected 192", hlo); else n_pass++;
      n_chk++; if (hbad !== 0) $display("FAIL hsync_window: got %0d bad pixels expected 0", hbad); else n_pass++;
      n_chk++; if (vbad !== 0) $display("FAIL video_on_window: got %0d bad pixels expected 0", vbad); else n_pass++;
      n_chk++; if (bad !== 0) $display("FAIL line_model: %0d bad, first %s", bad, msg); else n_pass++;
   endtask

   task automatic test_frame();
      longint fse[$];
      int bad = 0, vact = 0, lcnt = 0, vsbad = 0, xmax = 0, ymax = 0;
      string msg;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            if (obs(i) !== exp_out(i)) begin
               if (bad == 0) msg = $sformatf("dut%0d got %p expected %p", i, obs(i), exp_out(i));
               bad++;
            end
         if (fs[1] === 1'b1) fse.push_back(ec[1]);
         if (fse.size() == 1) begin
            if (vs[1] === SA[1]) vact++;
            if (ls[1] === 1'b1) lcnt++;
         end
         if ((vs[1] === SA[1]) !== (py[1] >= 10'd12 && py[1] <= 10'd13)) vsbad++;
         if (int'(px[1]) > xmax) xmax = int'(px[1]);
         if (int'(py[1]) > ymax) ymax = int'(py[1]);
      end
      n_chk++;
      if (fse.size() < 2 || fse[1] - fse[0] != 850 || fse[0] % 850 != 0)
         $display("FAIL frame_period: got %p expected multiples of 850 spaced 850", fse);
      else n_pass++;
      n_chk++; if (vact !== 100) $display("FAIL vsync_width: got %0d clk expected 100", vact); else n_pass++;
      n_chk++; if (lcnt !== 17) $display("FAIL lines_per_frame: got %0d expected 17", lcnt); else n_pass++;
      n_chk++; if (vsbad !== 0) $display("FAIL vsync_window: got %0d bad samples expected 0", vsbad); else n_pass++;
      n_chk++;
      if (xmax !== 24 || ymax !== 16) $display("FAIL coord_range: got max x %0d y %0d expected 24 16", xmax, ymax);
      else n_pass++;
      n_chk++; if (bad !== 0) $display("FAIL frame_model: %0d bad, first %s", bad, msg); else n_pass++;
   endtask

   task automatic test_enable();
      int n = 0, bad = 0, hold_bad = 0;
      out_t snap;
      string msg;
      do begin @(negedge clk); n++; end while (px[0] !== 10'd700 && n < 4000);
      n_chk++; if (px[0] !== 10'd700) $display("FAIL enable_reach_700: got %0d expected 700", px[0]); else n_pass++;
      en[0] = 1'b0;
      #1;
      snap = obs(0);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (obs(0) !== snap || tick[0] !== 1'b0) hold_bad++;
         for (int i = 0; i < 3; i++)
            if (obs(i) !== exp_out(i)) begin
               if (bad == 0) msg = $sformatf("dut%0d got %p expected %p", i, obs(i), exp_out(i));
               bad++;
            end
      end
      n_chk++; if (hold_bad !== 0) $display("FAIL enable_hold: got %0d changed samples expected 0", hold_bad); else n_pass++;
      en[0] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (px[0] === 10'd700 && n < 20);
      n_chk++; if (px[0] !== 10'd701) $display("FAIL enable_resume_x: got %0d expected 701", px[0]); else n_pass++;
      n_chk++; if (n !== 4) $display("FAIL enable_resume_latency: got %0d clk expected 4", n); else n_pass++;
      n_chk++; if (bad !== 0) $display("FAIL enable_model: %0d bad, first %s", bad, msg); else n_pass++;
   endtask

   task automatic test_async_reset();
      int n = 0, bad = 0;
      longint first_fs = -1, first_ls = -1;
      string msg;
      do begin @(negedge clk); n++; end while (py[1] !== 10'd8 && n < 2000);
      n_chk++; if (py[1] !== 10'd8) $display("FAIL async_reach_y8: got %0d expected 8", py[1]); else n_pass++;
      @(posedge clk);
      #2;
      rst_n[1] = 1'b0;
      #1;
      n_chk++;
      if (obs(1) !== reset_val(1)) $display("FAIL async_reset_immediate: got %p expected %p", obs(1), reset_val(1));
      else n_pass++;
      repeat (2) @(negedge clk);
      n_chk++;
      if (obs(1) !== reset_val(1)) $display("FAIL async_reset_hold: got %p expected %p", obs(1), reset_val(1));
      else n_pass++;
      rst_n[1] = 1'b1;
      for (int k = 0; k < 900; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            if (obs(i) !== exp_out(i)) begin
               if (bad == 0) msg = $sformatf("dut%0d got %p expected %p", i, obs(i), exp_out(i));
               bad++;
            end
         if (fs[1] === 1'b1 && first_fs < 0) first_fs = ec[1];
         if (ls[1] === 1'b1 && first_ls < 0) first_ls = ec[1];
      end
      n_chk++; if (first_ls !== 50) $display("FAIL async_first_line: got %0d expected 50", first_ls); else n_pass++;
      n_chk++; if (first_fs !== 850) $display("FAIL async_first_frame: got %0d expected 850", first_fs); else n_pass++;
      n_chk++; if (bad !== 0) $display("FAIL async_model: %0d bad, first %s", bad, msg); else n_pass++;
   endtask

   task automatic test_clkdiv1();
      int bad = 0, tbad = 0;
      int lsk[$];
      string msg;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (tick[2] !== en[2]) tbad++;
         for (int i = 0; i < 3; i++)
            if (obs(i) !== exp_out(i)) begin
               if (bad == 0) msg = $sformatf("dut%0d got %p expected %p", i, obs(i), exp_out(i));
               bad++;
            end
         en[2] = ($urandom % 4) != 0;
      end
      n_chk++; if (tbad !== 0) $display("FAIL div1_tick_eq_en: got %0d bad samples expected 0", tbad); else n_pass++;
      en[2] = 1'b1;
      for (int k = 0; k < 1800; k++) begin
         @(negedge clk);
         if (ls[2] === 1'b1) lsk.push_back(k);
         for (int i = 0; i < 3; i++)
            if (obs(i) !== exp_out(i)) begin
               if (bad == 0) msg = $sformatf("dut%0d got %p expected %p", i, obs(i), exp_out(i));
               bad++;
            end
      end
      n_chk++;
      if (lsk.size() < 2 || lsk[1] - lsk[0] != 800) $display("FAIL div1_line_period: got %p expected spacing 800", lsk);
      else n_pass++;
      n_chk++; if (bad !== 0) $display("FAIL div1_model: %0d bad, first %s", bad, msg); else n_pass++;
   endtask

   task automatic test_random_enable();
      int bad = 0;
      string msg;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++)
            if (obs(i) !== exp_out(i)) begin
               if (bad == 0) msg = $sformatf("dut%0d got %p expected %p", i, obs(i), exp_out(i));
               bad++;
            end
         for (int i = 0; i < 3; i++) en[i] = ($urandom % 3) != 0;
      end
      n_chk++; if (bad !== 0) $display("FAIL random_enable_model: %0d bad, first %s", bad, msg); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_enable();
      test_async_reset();
      test_clkdiv1();
      test_random_enable();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
